// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Unlisted size codes (011/110/111) fall into word access.
  function automatic acc_size_e acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane selection and sign/zero extension of a 32-bit bus word.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] result_o
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (off_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    result_o = rdata_i;
    case (funct3_e'(funct3_i))
      LB:      result_o = 32'($signed(byte_sel));
      LBU:     result_o = {24'd0, byte_sel};
      LH:      result_o = 32'($signed(half_sel));
      LHU:     result_o = {16'd0, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage LSU: one outstanding req/ack data-bus access with store steering and load extension.
// Build option LSU_MISALIGN_TRAP_EN: misaligned ops skip the bus and pulse misalign_o instead of truncating.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          mem_read_m,
  input  logic          mem_write_m,
  input  logic [2:0]    funct3_m,
  input  logic [DW-1:0] alu_out_m,
  input  logic [DW-1:0] write_data_m,
  input  logic [RW-1:0] rd_m,
  output logic          dbus_req_o,
  output logic          dbus_we_o,
  output logic [DW-1:0] dbus_addr_o,
  output logic [3:0]    dbus_be_o,
  output logic [DW-1:0] dbus_wdata_o,
  input  logic          dbus_ack_i,
  input  logic [DW-1:0] dbus_rdata_i,
  output logic          stall_o,
  output logic          load_valid_o,
  output logic [DW-1:0] load_data_o,
  output logic [RW-1:0] load_rd_o,
  output logic          misalign_o
);

  lsu_state_e    state_q;
  logic          req_q;
  logic          we_q;
  logic [DW-1:0] addr_q;
  logic [3:0]    be_q;
  logic [DW-1:0] wdata_q;
  logic          load_valid_q;
  logic [DW-1:0] load_data_q;
  logic [RW-1:0] load_rd_q;
  logic          misalign_q;
  logic [1:0]    off_q;
  logic [2:0]    funct3_q;

  logic          op_m;
  acc_size_e     size_m;
  logic [1:0]    off_d;
  logic [3:0]    be_d;
  logic [DW-1:0] wdata_d;
  logic [DW-1:0] align_res;
  logic          trap_m;

  // Offsets are truncated to natural alignment so a misaligned access degrades to the aligned one.
  always_comb begin
    op_m    = mem_read_m | mem_write_m;
    size_m  = acc_size(funct3_m);
    off_d   = 2'b00;
    be_d    = BE_WORD;
    wdata_d = write_data_m;
    case (size_m)
      SZ_BYTE: begin
        off_d   = alu_out_m[1:0];
        wdata_d = {4{write_data_m[7:0]}};
        if (mem_write_m) be_d = BE_BYTE << off_d;
      end
      SZ_HALF: begin
        off_d   = {alu_out_m[1], 1'b0};
        wdata_d = {2{write_data_m[15:0]}};
        if (mem_write_m) be_d = BE_HALF << off_d;
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_m = ((size_m == SZ_HALF) && alu_out_m[0]) ||
                  ((size_m == SZ_WORD) && (alu_out_m[1:0] != 2'b00));
`else
  assign trap_m = 1'b0;
`endif

  lsu_load_align u_align (
    .off_i    (off_q),
    .funct3_i (funct3_q),
    .rdata_i  (dbus_rdata_i),
    .result_o (align_res)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      load_rd_q    <= '0;
      misalign_q   <= 1'b0;
      off_q        <= '0;
      funct3_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_m) begin
            off_q    <= off_d;
            funct3_q <= funct3_m;
            if (!mem_write_m) load_rd_q <= rd_m;
            if (trap_m) begin
              misalign_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              req_q   <= 1'b1;
              we_q    <= mem_write_m;
              addr_q  <= {alu_out_m[DW-1:2], 2'b00};
              be_q    <= be_d;
              wdata_q <= wdata_d;
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          if (dbus_ack_i) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            if (!we_q) begin
              load_valid_q <= 1'b1;
              load_data_q  <= align_res;
            end
            state_q <= DONE;
          end
        end
        DONE: begin
          // The op still on the M inputs is the one just completed; never relaunch it.
          load_valid_q <= 1'b0;
          misalign_q   <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_o      = (state_q == REQ) || ((state_q == IDLE) && op_m);
  assign dbus_req_o   = req_q;
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_be_o    = be_q;
  assign dbus_wdata_o = wdata_q;
  assign load_valid_o = load_valid_q;
  assign load_data_o  = load_data_q;
  assign load_rd_o    = load_rd_q;
  assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: a byte-addressed memory model predicts bus traffic and load results.
`timescale 1ns/1ps
module tb_lsu_mem_stage;
  localparam int DW = 32;
  localparam int RW = 5;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          mem_read_m = 1'b0;
  logic          mem_write_m = 1'b0;
  logic [2:0]    funct3_m = '0;
  logic [DW-1:0] alu_out_m = '0;
  logic [DW-1:0] write_data_m = '0;
  logic [RW-1:0] rd_m = '0;
  logic          dbus_req_o, dbus_we_o;
  logic [DW-1:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]    dbus_be_o;
  logic          dbus_ack_i = 1'b0;
  logic [DW-1:0] dbus_rdata_i = '0;
  logic          stall_o, load_valid_o, misalign_o;
  logic [DW-1:0] load_data_o;
  logic [RW-1:0] load_rd_o;

  lsu_mem_stage #(.DW(DW), .RW(RW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_read_m(mem_read_m), .mem_write_m(mem_write_m), .funct3_m(funct3_m),
    .alu_out_m(alu_out_m), .write_data_m(write_data_m), .rd_m(rd_m),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i),
    .stall_o(stall_o), .load_valid_o(load_valid_o), .load_data_o(load_data_o),
    .load_rd_o(load_rd_o), .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { bit we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_t;
  typedef struct { bit mis; logic [31:0] data; logic [4:0] rd; } res_t;

  bus_t bus_q[$];
  res_t res_q[$];
  int   dly_q[$];
  logic [7:0]  ref_mem [int unsigned];
  logic [31:0] slv_mem [int unsigned];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   resp_en = 1'b1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] init_word(input int unsigned wa);
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [7:0] ref_rd(input int unsigned a);
    logic [31:0] w;
    if (ref_mem.exists(a)) return ref_mem[a];
    w = init_word(a >> 2) >> (8 * (a & 3));
    return w[7:0];
  endfunction

  function automatic logic [31:0] slv_rd(input int unsigned wa);
    if (slv_mem.exists(wa)) return slv_mem[wa];
    return init_word(wa);
  endfunction

  task automatic preload(input int unsigned a, input logic [31:0] w);
    slv_mem[a >> 2] = w;
    for (int i = 0; i < 4; i++) ref_mem[a + i] = w[8*i +: 8];
  endtask

  // Issue one op as the pipeline would, push its expectations, hold it until stall_o drops.
  task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rdr, input int d);
    int sz, m, cyc, exp_stall;
    logic [31:0] aa, val, wexp;
    bit mis, trapped;
    bus_t b;
    res_t r;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    aa = a & ~(32'(sz) - 32'd1);
    mis = (aa != a);
    trapped = TRAP && mis;
    if (trapped) begin
      r.mis = 1'b1; r.data = '0; r.rd = '0;
      res_q.push_back(r);
      exp_stall = 1;
    end else begin
      b.we = wr;
      b.addr = a & 32'hFFFF_FFFC;
      if (wr) begin
        m = ((1 << sz) - 1) << (aa & 3);
        b.be = m[3:0];
        for (int i = 0; i < 4; i++) wexp[8*i +: 8] = wd[8*(i % sz) +: 8];
        b.wdata = wexp;
        for (int i = 0; i < sz; i++) ref_mem[aa + i] = wd[8*i +: 8];
      end else begin
        b.be = 4'hF;
        b.wdata = '0;
        val = '0;
        for (int i = 0; i < sz; i++) val = val | (32'(ref_rd(aa + i)) << (8 * i));
        if (!f3[2] && sz == 1) val = {{24{val[7]}}, val[7:0]};
        if (!f3[2] && sz == 2) val = {{16{val[15]}}, val[15:0]};
        r.mis = 1'b0; r.data = val; r.rd = rdr;
        res_q.push_back(r);
      end
      bus_q.push_back(b);
      dly_q.push_back(d);
      exp_stall = d + 2;
    end
    mem_read_m = rd; mem_write_m = wr; funct3_m = f3;
    alu_out_m = a; write_data_m = wd; rd_m = rdr;
    cyc = 0;
    forever begin
      #1;
      if (stall_o !== 1'b1 || cyc > 60) break;
      cyc++;
      @(posedge clk_i); #1;
    end
    chk("stall_cycles", 32'(cyc), 32'(exp_stall));
    chk("valid_in_done", 32'(load_valid_o), 32'(!wr && !trapped));
    chk("misalign_in_done", 32'(misalign_o), 32'(trapped));
    @(posedge clk_i); #1;
    mem_read_m = 1'b0; mem_write_m = 1'b0;
  endtask

  // Bus slave: checks each new request, holds ack off for the planned delay, keeps its own memory.
  initial begin : responder
    bit in_txn;
    int cnt;
    bus_t snap, e;
    logic [31:0] w;
    int unsigned wa;
    in_txn = 1'b0;
    cnt = 0;
    forever begin
      @(posedge clk_i); #1;
      if (!resp_en) begin in_txn = 1'b0; continue; end
      dbus_ack_i = 1'b0;
      if (rst_i) begin in_txn = 1'b0; continue; end
      if (dbus_req_o) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          snap.we = dbus_we_o; snap.addr = dbus_addr_o; snap.be = dbus_be_o; snap.wdata = dbus_wdata_o;
          cnt = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
          if (bus_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL spurious_request: addr %h with no pending op", dbus_addr_o);
          end else begin
            e = bus_q.pop_front();
            chk("bus_we", 32'(dbus_we_o), 32'(e.we));
            chk("bus_addr", dbus_addr_o, e.addr);
            chk("bus_be", 32'(dbus_be_o), 32'(e.be));
            if (e.we) chk("bus_wdata", dbus_wdata_o, e.wdata);
          end
        end else begin
          chk("stable_we", 32'(dbus_we_o), 32'(snap.we));
          chk("stable_addr", dbus_addr_o, snap.addr);
          chk("stable_be", 32'(dbus_be_o), 32'(snap.be));
          chk("stable_wdata", dbus_wdata_o, snap.wdata);
        end
        if (cnt == 0) begin
          dbus_ack_i = 1'b1;
          wa = dbus_addr_o >> 2;
          if (dbus_we_o) begin
            w = slv_rd(wa);
            for (int i = 0; i < 4; i++) if (dbus_be_o[i]) w[8*i +: 8] = dbus_wdata_o[8*i +: 8];
            slv_mem[wa] = w;
            dbus_rdata_i = $urandom();
          end else begin
            dbus_rdata_i = slv_rd(wa);
          end
          in_txn = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Result monitor: every load_valid_o / misalign_o pulse must match the oldest expectation.
  initial begin : monitor
    res_t e;
    forever begin
      @(posedge clk_i); #1;
      if (rst_i) continue;
      if (load_valid_o || misalign_o) begin
        if (res_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_result: valid %b misalign %b data %h", load_valid_o, misalign_o, load_data_o);
        end else begin
          e = res_q.pop_front();
          chk("res_misalign", 32'(misalign_o), 32'(e.mis));
          chk("res_valid", 32'(load_valid_o), 32'(!e.mis));
          if (!e.mis) begin
            chk("load_data", load_data_o, e.data);
            chk("load_rd", 32'(load_rd_o), 32'(e.rd));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [2:0] f3;
    int kind;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req", 32'(dbus_req_o), 32'd0);
    chk("rst_we", 32'(dbus_we_o), 32'd0);
    chk("rst_addr", dbus_addr_o, 32'd0);
    chk("rst_be", 32'(dbus_be_o), 32'd0);
    chk("rst_wdata", dbus_wdata_o, 32'd0);
    chk("rst_load_valid", 32'(load_valid_o), 32'd0);
    chk("rst_load_data", load_data_o, 32'd0);
    chk("rst_load_rd", 32'(load_rd_o), 32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    @(negedge clk_i); rst_i = 1'b0;
    @(posedge clk_i); #1;

    preload(32'h200, 32'h80FF_0000);
    preload(32'h0A0, 32'h8001_0000);
    do_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd0, 1);
    do_op(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 5'd7, 0);
    do_op(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 5'd7, 0);
    do_op(1'b1, 1'b0, 3'b001, 32'h0A2, 32'h0, 5'd4, 2);
    do_op(1'b0, 1'b1, 3'b001, 32'h0A2, 32'h1234_5678, 5'd0, 0);
    do_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd9, 1);
    do_op(1'b1, 1'b1, 3'b000, 32'h105, 32'h0000_00A5, 5'd2, 0);
    do_op(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 5'd11, 0);

    // Reset while a load waits for ack: request must drop at once and the late ack be ignored.
    resp_en = 1'b0;
    mem_read_m = 1'b1; funct3_m = 3'b010; alu_out_m = 32'h300; rd_m = 5'd3;
    #1 chk("rst_test_stall_op", 32'(stall_o), 32'd1);
    @(posedge clk_i); #1;
    chk("rst_test_req_up", 32'(dbus_req_o), 32'd1);
    @(posedge clk_i); #1;
    chk("rst_test_req_held", 32'(dbus_req_o), 32'd1);
    #2 rst_i = 1'b1; mem_read_m = 1'b0;
    #1;
    chk("rst_test_req_drop", 32'(dbus_req_o), 32'd0);
    chk("rst_test_stall_idle", 32'(stall_o), 32'd0);
    @(negedge clk_i); rst_i = 1'b0;
    @(posedge clk_i); #1;
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'hCAFE_F00D;
    @(posedge clk_i); #1;
    dbus_ack_i = 1'b0;
    repeat (3) begin
      chk("rst_test_no_req", 32'(dbus_req_o), 32'd0);
      chk("rst_test_no_valid", 32'(load_valid_o), 32'd0);
      @(posedge clk_i); #1;
    end
    resp_en = 1'b1;
    @(posedge clk_i); #1;

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) f3 = 3'($urandom_range(0, 7));
      else begin
        case ($urandom_range(0, 5))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
          3: f3 = 3'b011; 4: f3 = 3'b110; default: f3 = 3'b111;
        endcase
      end
      do_op(kind != 1, kind != 0, f3, 32'($urandom_range(0, 63)), $urandom(),
            5'($urandom_range(0, 31)), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
    end

    repeat (5) @(posedge clk_i);
    #1;
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("res_q_drained", 32'(res_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Memory-stage load/store unit of the 3-stage RISC-V core. It consumes the execute→memory pipeline register outputs (address in `alu_out_m`, store data in `write_data_m`, destination in `rd_m`) and runs a single-outstanding request/acknowledge transaction on the data bus. It performs byte-lane steering for stores and alignment plus sign/zero extension for loads. It stalls the pipeline until each access completes.

## Interface
- `DW`, 32, data/address width (only 32 supported)
- `RW`, 5, register index width
- `clk_i` in 1 clock
- `rst_i` in 1 reset; asynchronous, active-high
- `mem_read_m` in 1 load in M stage
- `mem_write_m` in 1 store in M stage
- `funct3_m` in 3 access size/sign
- `alu_out_m` in DW byte address
- `write_data_m` in DW store data
- `rd_m` in RW load destination
- `dbus_req_o` out 1 bus request, held until ack
- `dbus_we_o` out 1 1 = write
- `dbus_addr_o` out DW word-aligned address, bits [1:0] = 0
- `dbus_be_o` out 4 byte enables
- `dbus_wdata_o` out DW lane-replicated store data
- `dbus_ack_i` in 1 one-cycle completion strobe
- `dbus_rdata_i` in DW read data, valid with ack
- `stall_o` out 1 hold IF/E/M registers
- `load_valid_o` out 1 load result valid (1 cycle)
- `load_data_o` out DW extended load result
- `load_rd_o` out RW destination of `load_data_o`
- `misalign_o` out 1 misaligned-access pulse

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - An op is `mem_read_m | mem_write_m`.
  - On an op: latch addr, funct3, data, rd and we; go to REQ. `stall_o` = 1 combinationally.
  - If both read and write are set, the access is a write.
- REQ:
  - `dbus_req_o` = 1 and all bus outputs stay stable until `dbus_ack_i`.
  - On ack: capture extended rdata (loads); go to DONE.
  - `stall_o` = 1.
- DONE:
  - `stall_o` = 0, so the pipeline advances at the end of this cycle.
  - `load_valid_o` = 1 for loads only.
  - Always go to IDLE. The op still visible on M inputs is the completed one and is never relaunched.
- Store byte enables:
  - SB (000): `be` = 0001 << addr[1:0], wdata = byte ×4.
  - SH (001): `be` = 0011 << {addr[1],0}, wdata = half ×2.
  - SW (010): `be` = 1111.
- Loads (`be` = 1111 on bus), lane selected by latched addr[1:0]:
  - LB (000) / LBU (100): byte, sign-/zero-extended.
  - LH (001) / LHU (101): half, sign-/zero-extended.
  - LW (010): full word.
- funct3 011/110/111 are treated as word access.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0. Behaviour depends on the macro (see Configuration).
- `dbus_ack_i` outside REQ is ignored.

## Timing
- Reset values: state IDLE; `dbus_req_o`, `dbus_we_o`, `load_valid_o`, `misalign_o` = 0; `dbus_addr_o`, `dbus_be_o`, `dbus_wdata_o`, `load_data_o`, `load_rd_o` = 0.
- Bus outputs are registered. `stall_o` is combinational from state and M inputs.
- Op seen in cycle N:
  - `dbus_req_o` is high from N+1.
  - With ack in cycle N+k (k≥1), DONE is cycle N+k+1.
  - Minimum occupancy is 3 cycles.
- Reset mid-operation drops `dbus_req_o` immediately; the transaction is abandoned and no `load_valid_o` is produced.
- Back-to-back ops: the next op is sampled in the cycle after DONE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned op in IDLE goes directly to DONE with no bus request.
  - `misalign_o` = 1 for that DONE cycle; `load_valid_o` = 0.
  - Stores are suppressed.
- Undefined:
  - `misalign_o` is tied 0.
  - Address low bits are truncated to natural alignment (half: addr[0]=0; word: addr[1:0]=0) and the access proceeds normally.

## Structure
- `lsu_pkg`: `lsu_state_e` (IDLE/REQ/DONE), `funct3_e` size codes (LB, LH, LW, LBU, LHU), `BE_*` constants.
- Sub-module `lsu_load_align`: combinational lane select plus sign/zero extension (addr[1:0], funct3, rdata → result). It is instantiated once.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, ack after 2 cycles → req addr 0x100, be 1111, wdata 0xDEADBEEF, `we`=1, `stall_o` high 3 cycles, no `load_valid_o`.
- LB addr 0x203, rdata 0x80FF_0000, rd 7 → `load_data_o` 0xFFFF_FF80, `load_rd_o` 7; LBU on the same access → 0x0000_0080.
- SH addr 0x0A2, data 0x1234_5678 → `be` 1100, wdata 0x5678_5678; LH addr 0x0A2, rdata 0x8001_0000 → 0xFFFF_8001.
- LW addr 0x101 with `LSU_MISALIGN_TRAP_EN` → no `dbus_req_o`, `misalign_o` pulse, `load_valid_o` 0. Without the macro → bus addr 0x100, normal load.
- `rst_i` asserted while in REQ awaiting ack → `dbus_req_o` 0 immediately, state IDLE, later ack ignored.
- Two consecutive loads, ack in the same cycle as req → each completes in 3 cycles, two distinct `load_valid_o` pulses, and the second op is never relaunched spuriously.
